// File: rtl/state_controller.sv
// Moore control FSM sequencing MOV/ALU instructions through register-file and ALU strobes.
// Optional feature: define ILLEGAL_TRAP_EN to trap illegal instructions in a sticky ERR state.
module state_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       w,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       write,
   output logic       err
);

   localparam int unsigned OPC_W  = 3;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned NSEL_W = 3;
   localparam int unsigned VSEL_W = 2;

   localparam logic [OPC_W-1:0]  OPC_MOV  = 3'b110;
   localparam logic [OPC_W-1:0]  OPC_ALU  = 3'b101;
   localparam logic [NSEL_W-1:0] NSEL_RN  = 3'b000;
   localparam logic [NSEL_W-1:0] NSEL_RD  = 3'b001;
   localparam logic [NSEL_W-1:0] NSEL_RM  = 3'b010;
   localparam logic [VSEL_W-1:0] VSEL_C   = 2'b00;
   localparam logic [VSEL_W-1:0] VSEL_IMM = 2'b01;

   typedef enum logic [2:0] {
      ST_WAIT      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_WRITE_IMM = 3'd2,
      ST_GET_A     = 3'd3,
      ST_GET_B     = 3'd4,
      ST_EXEC      = 3'd5,
      ST_WRITE_REG = 3'd6
`ifdef ILLEGAL_TRAP_EN
      , ST_ERR     = 3'd7
`endif
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [OPC_W-1:0]   r_opcode;
   logic [OP_W-1:0]    r_op;

   logic               r_w;
   logic [NSEL_W-1:0]  r_nsel;
   logic [VSEL_W-1:0]  r_vsel;
   logic               r_loada;
   logic               r_loadb;
   logic               r_loadc;
   logic               r_loads;
   logic               r_asel;
   logic               r_write;

   logic               w_ready_next;
   logic [NSEL_W-1:0]  w_nsel_next;
   logic [VSEL_W-1:0]  w_vsel_next;
   logic               w_loada_next;
   logic               w_loadb_next;
   logic               w_loadc_next;
   logic               w_loads_next;
   logic               w_asel_next;
   logic               w_write_next;

   logic               w_is_mov_imm;
   logic               w_is_mov_reg;
   logic               w_is_alu;
   logic               w_is_cmp;
   logic               w_is_mvn;

   // Decode of the latched instruction; stable for the whole instruction.
   assign w_is_mov_imm = (r_opcode == OPC_MOV) && (r_op == 2'b10);
   assign w_is_mov_reg = (r_opcode == OPC_MOV) && (r_op == 2'b00);
   assign w_is_alu     = (r_opcode == OPC_ALU);
   assign w_is_cmp     = w_is_alu && (r_op == 2'b01);
   assign w_is_mvn     = w_is_alu && (r_op == 2'b11);

`ifdef ILLEGAL_TRAP_EN
   logic r_err;
   logic w_err_next;
`endif

   // Next state plus the Moore outputs of that state, registered below.
   always_comb begin
      w_state_next = r_state;
      w_ready_next = 1'b0;
      w_nsel_next  = NSEL_RN;
      w_vsel_next  = VSEL_C;
      w_loada_next = 1'b0;
      w_loadb_next = 1'b0;
      w_loadc_next = 1'b0;
      w_loads_next = 1'b0;
      w_asel_next  = 1'b0;
      w_write_next = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      w_err_next   = 1'b0;
`endif

      case (r_state)
         ST_WAIT:      if (s) w_state_next = ST_DECODE;
         ST_DECODE: begin
            if (w_is_mov_imm)                   w_state_next = ST_WRITE_IMM;
            else if (w_is_mov_reg || w_is_mvn)  w_state_next = ST_GET_B;
            else if (w_is_alu)                  w_state_next = ST_GET_A;
`ifdef ILLEGAL_TRAP_EN
            else                                w_state_next = ST_ERR;
`else
            else                                w_state_next = ST_WAIT;
`endif
         end
         ST_WRITE_IMM: w_state_next = ST_WAIT;
         ST_GET_A:     w_state_next = ST_GET_B;
         ST_GET_B:     w_state_next = ST_EXEC;
         ST_EXEC:      w_state_next = w_is_cmp ? ST_WAIT : ST_WRITE_REG;
         ST_WRITE_REG: w_state_next = ST_WAIT;
`ifdef ILLEGAL_TRAP_EN
         ST_ERR:       w_state_next = ST_ERR;
`endif
         default:      w_state_next = ST_WAIT;
      endcase

      // The instruction is already latched whenever the next state depends on it.
      case (w_state_next)
         ST_WAIT:      w_ready_next = 1'b1;
         ST_WRITE_IMM: begin
            w_nsel_next  = NSEL_RN;
            w_vsel_next  = VSEL_IMM;
            w_write_next = 1'b1;
         end
         ST_GET_A: begin
            w_nsel_next  = NSEL_RN;
            w_loada_next = 1'b1;
         end
         ST_GET_B: begin
            w_nsel_next  = NSEL_RM;
            w_loadb_next = 1'b1;
         end
         ST_EXEC: begin
            w_asel_next  = w_is_mov_reg || w_is_mvn;
            w_loads_next = w_is_cmp;
            w_loadc_next = !w_is_cmp;
         end
         ST_WRITE_REG: begin
            w_nsel_next  = NSEL_RD;
            w_vsel_next  = VSEL_C;
            w_write_next = 1'b1;
         end
`ifdef ILLEGAL_TRAP_EN
         ST_ERR:       w_err_next = 1'b1;
`endif
         default: ;
      endcase
   end

   // State, instruction latch and output registers; reset overrides s.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_WAIT;
         r_opcode <= '0;
         r_op     <= '0;
         r_w      <= 1'b1;
         r_nsel   <= NSEL_RN;
         r_vsel   <= VSEL_C;
         r_loada  <= 1'b0;
         r_loadb  <= 1'b0;
         r_loadc  <= 1'b0;
         r_loads  <= 1'b0;
         r_asel   <= 1'b0;
         r_write  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         r_err    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_WAIT) && s) begin
            r_opcode <= opcode;
            r_op     <= op;
         end
         r_w     <= w_ready_next;
         r_nsel  <= w_nsel_next;
         r_vsel  <= w_vsel_next;
         r_loada <= w_loada_next;
         r_loadb <= w_loadb_next;
         r_loadc <= w_loadc_next;
         r_loads <= w_loads_next;
         r_asel  <= w_asel_next;
         r_write <= w_write_next;
`ifdef ILLEGAL_TRAP_EN
         r_err   <= w_err_next;
`endif
      end
   end

   assign w     = r_w;
   assign nsel  = r_nsel;
   assign vsel  = r_vsel;
   assign loada = r_loada;
   assign loadb = r_loadb;
   assign loadc = r_loadc;
   assign loads = r_loads;
   assign asel  = r_asel;
   assign bsel  = 1'b0;
   assign write = r_write;
`ifdef ILLEGAL_TRAP_EN
   assign err   = r_err;
`else
   assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_state_controller.sv
// Self-checking bench for state_controller: vector table plus hand-written reset/hold/trap sequences.
module tb_state_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       loada, loadb, loadc, loads, asel, bsel, write, err;

   state_controller dut (
      .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
      .w(w), .nsel(nsel), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .write(write), .err(err)
   );

   always #5 clk = ~clk;

   // Output word: {w, nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel, bsel, write, err}
   logic [13:0] obs;
   assign obs = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err};

   localparam logic [13:0] E_WAIT = 14'b1_000_00_0000_0_0_0_0;
   localparam logic [13:0] E_DEC  = 14'b0_000_00_0000_0_0_0_0;
   localparam logic [13:0] E_WIMM = 14'b0_000_01_0000_0_0_1_0;
   localparam logic [13:0] E_GETA = 14'b0_000_00_1000_0_0_0_0;
   localparam logic [13:0] E_GETB = 14'b0_010_00_0100_0_0_0_0;
   localparam logic [13:0] E_XADD = 14'b0_000_00_0010_0_0_0_0;
   localparam logic [13:0] E_XCMP = 14'b0_000_00_0001_0_0_0_0;
   localparam logic [13:0] E_XMVN = 14'b0_000_00_0010_1_0_0_0;
   localparam logic [13:0] E_WREG = 14'b0_001_00_0000_0_0_1_0;
   localparam logic [13:0] E_ERR  = 14'b0_000_00_0000_0_0_0_1;

   typedef struct {
      string            name;
      logic [2:0]       opc;
      logic [1:0]       op;
      int               n;
      logic [5:0][13:0] seq;
   } vec_t;

   vec_t        tv[$];
   logic [13:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic vec_t mkv(input string nm, input logic [2:0] c, input logic [1:0] o,
                                input int n, input logic [13:0] s0, input logic [13:0] s1,
                                input logic [13:0] s2, input logic [13:0] s3,
                                input logic [13:0] s4, input logic [13:0] s5);
      vec_t v;
      v.name = nm; v.opc = c; v.op = o; v.n = n;
      v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
      v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
      return v;
   endfunction

   task automatic check(input string nm);
      logic [13:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %b", nm, obs);
      end else begin
         e = exp_q.pop_front();
         if (obs !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, obs, e);
         end
      end
   endtask

   task automatic tick_check(input string nm, input logic [13:0] e);
      exp_q.push_back(e);
      @(posedge clk); #1;
      check(nm);
   endtask

   // Start one instruction, then scramble the inputs to prove the latch holds it.
   task automatic run_vec(input vec_t v);
      s = 1'b1; opcode = v.opc; op = v.op;
      for (int i = 0; i < v.n; i++) exp_q.push_back(v.seq[i]);
      for (int i = 0; i < v.n; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            s = 1'b0; opcode = 3'b000; op = ~v.op;
         end
         check($sformatf("%s c%0d", v.name, i));
      end
   endtask

   initial begin
      reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;

      tv.push_back(mkv("mov_imm", 3'b110, 2'b10, 3, E_DEC, E_WIMM, E_WAIT, E_WAIT, E_WAIT, E_WAIT));
      tv.push_back(mkv("mov_reg", 3'b110, 2'b00, 5, E_DEC, E_GETB, E_XMVN, E_WREG, E_WAIT, E_WAIT));
      tv.push_back(mkv("add",     3'b101, 2'b00, 6, E_DEC, E_GETA, E_GETB, E_XADD, E_WREG, E_WAIT));
      tv.push_back(mkv("cmp",     3'b101, 2'b01, 5, E_DEC, E_GETA, E_GETB, E_XCMP, E_WAIT, E_WAIT));
      tv.push_back(mkv("and",     3'b101, 2'b10, 6, E_DEC, E_GETA, E_GETB, E_XADD, E_WREG, E_WAIT));
      tv.push_back(mkv("mvn",     3'b101, 2'b11, 5, E_DEC, E_GETB, E_XMVN, E_WREG, E_WAIT, E_WAIT));
`ifndef ILLEGAL_TRAP_EN
      tv.push_back(mkv("ill_011", 3'b011, 2'b00, 2, E_DEC, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT));
      tv.push_back(mkv("ill_mov01", 3'b110, 2'b01, 2, E_DEC, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT));
      tv.push_back(mkv("ill_mov11", 3'b110, 2'b11, 2, E_DEC, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT));
`endif

      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(E_WAIT);
      check("reset_state");
      reset = 1'b0;
      tick_check("idle", E_WAIT);

      foreach (tv[i]) run_vec(tv[i]);

      // Reset in GET_B of an ADD aborts it before any write.
      s = 1'b1; opcode = 3'b101; op = 2'b00;
      tick_check("rb_dec", E_DEC);
      s = 1'b0;
      tick_check("rb_geta", E_GETA);
      tick_check("rb_getb", E_GETB);
      reset = 1'b1;
      tick_check("rb_abort", E_WAIT);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick_check($sformatf("rb_idle%0d", i), E_WAIT);

      // Reset in WRITE_IMM with s held: reset wins over s.
      s = 1'b1; opcode = 3'b110; op = 2'b10;
      tick_check("ri_dec", E_DEC);
      tick_check("ri_wimm", E_WIMM);
      reset = 1'b1;
      tick_check("ri_rst0", E_WAIT);
      tick_check("ri_rst1", E_WAIT);
      reset = 1'b0; s = 1'b0;
      tick_check("ri_idle", E_WAIT);

      // s held high: ignored mid-instruction, restarts with the new opcode back in WAIT.
      s = 1'b1; opcode = 3'b101; op = 2'b00;
      tick_check("sh_dec", E_DEC);
      opcode = 3'b110; op = 2'b10;
      tick_check("sh_geta", E_GETA);
      tick_check("sh_getb", E_GETB);
      tick_check("sh_exec", E_XADD);
      tick_check("sh_wreg", E_WREG);
      tick_check("sh_wait", E_WAIT);
      tick_check("sh_dec2", E_DEC);
      s = 1'b0;
      tick_check("sh_wimm", E_WIMM);
      tick_check("sh_done", E_WAIT);

`ifdef ILLEGAL_TRAP_EN
      // Illegal instruction traps in ERR until reset, even with s held.
      s = 1'b1; opcode = 3'b011; op = 2'b00;
      tick_check("tr_dec", E_DEC);
      for (int i = 0; i < 11; i++) tick_check($sformatf("tr_err%0d", i), E_ERR);
      reset = 1'b1;
      tick_check("tr_rst", E_WAIT);
      reset = 1'b0; s = 1'b0;
      tick_check("tr_idle", E_WAIT);
`endif

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
